clk_div_bank: RTL and testbench

- Parametrised bank of NUM_CH independent programmable clock dividers.
- Each channel produces a one-cycle tick (clock-enable pulse) and a 50% duty toggled output.
- Divisors are runtime-writable through a simple write port. Each new divisor is applied glitch-free at that channel's next terminal count.
- Sits between the board clock and slow consumers: display scan, debounce, blink and UART baud enables.

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_chan.sv | 55 +++++
 rtl/clk_div_bank.sv | 42 ++++
 tb/tb_clk_div_bank.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider bank.
// Channel index width, reset divisor, effective-divisor rule.
package clk_div_pkg;

    localparam int unsigned DEF_DIV  = 50000;
    localparam int unsigned MAX_CH   = 16;
    localparam int unsigned CH_IDX_W = 4;

    // Divisors 0 and 1 both mean "tick every enabled cycle".
    function automatic logic [31:0] eff_div(input logic [31:0] n);
        return (n < 32'd2) ? 32'd1 : n;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One programmable divider channel: tick pulse and square wave.
// New divisors are staged and taken at terminal count or while idle.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             tick,
    output logic             clk_div,
    output logic [WIDTH-1:0] div_active
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] pending_div;
    logic [WIDTH-1:0] active_div;
    logic [WIDTH-1:0] neff;
    logic             tc;

    assign neff = WIDTH'(eff_div(32'(active_div)));
    assign tc   = en && (count == (neff - WIDTH'(1)));

    assign div_active = active_div;

    // Counter, outputs and the staged divisor hand-over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            pending_div <= WIDTH'(DEFAULT_DIV);
            active_div  <= WIDTH'(DEFAULT_DIV);
            tick        <= 1'b0;
            clk_div     <= 1'b0;
        end else begin
            if (!en || tc) begin
                count <= '0;
            end else begin
                count <= count + WIDTH'(1);
            end
            tick    <= tc;
            clk_div <= clk_div ^ tc;
            if (wr) begin
                pending_div <= wr_data;
            end
            if (tc || !en) begin
                active_div <= pending_div;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers.
// Decodes the shared write port into per-channel strobes.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic                    wr_en,
    input  logic [CH_IDX_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]        wr_data,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       clk_div,
    output logic [NUM_CH*WIDTH-1:0] div_active
);

    logic [NUM_CH-1:0] wr_sel;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        // Out-of-range indices match no channel and are dropped.
        assign wr_sel[k] = wr_en && (wr_ch == CH_IDX_W'(k));

        clk_div_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en         (en[k]),
            .wr         (wr_sel[k]),
            .wr_data    (wr_data),
            .tick       (tick[k]),
            .clk_div    (clk_div[k]),
            .div_active (div_active[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: vector table plus
// hand-written sequences for write timing and async reset.
module tb_clk_div_bank;

    localparam int NC = 4;
    localparam int W  = 16;
    localparam logic [63:0] ALL_DEF = {4{16'd50000}};

    logic          clk;
    logic          rst;
    logic [NC-1:0] en;
    logic          wr_en;
    logic [3:0]    wr_ch;
    logic [W-1:0]  wr_data;
    logic [NC-1:0] tick;
    logic [NC-1:0] clk_div;
    logic [NC*W-1:0] div_active;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [3:0]  en;
        logic        wr_en;
        logic [3:0]  wr_ch;
        logic [15:0] wr_data;
        logic        exp_tick;
        logic        exp_clk;
        logic [15:0] exp_div;
    } vec_t;

    vec_t tbl[$];

    logic exp_tick;
    logic exp_clk;
    logic [15:0] exp_div;

    clk_div_bank #(
        .NUM_CH      (NC),
        .WIDTH       (W),
        .DEFAULT_DIV (50000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .tick       (tick),
        .clk_div    (clk_div),
        .div_active (div_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] v_en,
                       input logic v_wr,
                       input logic [3:0] v_ch,
                       input logic [15:0] v_data,
                       input logic v_tick,
                       input logic v_clk,
                       input logic [15:0] v_div);
        vec_t v;
        v.en       = v_en;
        v.wr_en    = v_wr;
        v.wr_ch    = v_ch;
        v.wr_data  = v_data;
        v.exp_tick = v_tick;
        v.exp_clk  = v_clk;
        v.exp_div  = v_div;
        tbl.push_back(v);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b0;
        en      = '0;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_data = '0;

        // Channel 0 table: program N=4 idle, run, pause, resume.
        add(4'b0000, 1'b1, 4'd0, 16'd4, 1'b0, 1'b0, 16'd50000);
        add(4'b0000, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 16'd4);
        for (int e = 1; e <= 12; e++)
            add(4'b0001, 1'b0, 4'd0, 16'd0,
                (e % 4) == 0, ((e / 4) % 2) == 1, 16'd4);
        for (int e = 13; e <= 14; e++)
            add(4'b0001, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 16'd4);
        for (int e = 0; e < 3; e++)
            add(4'b0000, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 16'd4);
        for (int e = 1; e <= 4; e++)
            add(4'b0001, 1'b0, 4'd0, 16'd0,
                e == 4, e < 4, 16'd4);
        add(4'b0001, 1'b1, 4'd7, 16'd9, 1'b0, 1'b0, 16'd4);
        add(4'b0001, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 16'd4);

        // Reset held three cycles.
        #1 rst = 1'b1;
        #1;
        check("rst_tick_async", 64'(tick), 64'd0);
        repeat (3) step();
        rst = 1'b0;
        step();
        for (int k = 0; k < NC; k++) begin
            check($sformatf("reset_tick%0d", k),
                  64'(tick[k]), 64'd0);
            check($sformatf("reset_clk%0d", k),
                  64'(clk_div[k]), 64'd0);
            check($sformatf("reset_div%0d", k),
                  64'(div_active[k*W +: W]), 64'd50000);
        end

        foreach (tbl[i]) begin
            en      = tbl[i].en;
            wr_en   = tbl[i].wr_en;
            wr_ch   = tbl[i].wr_ch;
            wr_data = tbl[i].wr_data;
            step();
            check($sformatf("tbl%0d_tick", i),
                  64'(tick[0]), 64'(tbl[i].exp_tick));
            check($sformatf("tbl%0d_clk", i),
                  64'(clk_div[0]), 64'(tbl[i].exp_clk));
            check($sformatf("tbl%0d_div", i),
                  64'(div_active[0 +: W]), 64'(tbl[i].exp_div));
        end
        wr_en = 1'b0;
        check("bad_ch_write", 64'(div_active),
              {16'd50000, 16'd50000, 16'd50000, 16'd4});
        check("bad_ch_quiet", 64'(tick[3:1]), 64'd0);

        // Channel 1: N=5, then N=3 written on the tc cycle.
        en      = '0;
        wr_en   = 1'b1;
        wr_ch   = 4'd1;
        wr_data = 16'd5;
        step();
        wr_en = 1'b0;
        step();
        check("ch1_div5", 64'(div_active[W +: W]), 64'd5);
        en      = 4'b0010;
        exp_clk = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            wr_en   = (e == 5);
            wr_data = 16'd3;
            step();
            exp_tick = (e == 5) || (e == 10) ||
                       (e == 13) || (e == 16);
            exp_clk  = exp_clk ^ exp_tick;
            exp_div  = (e < 10) ? 16'd5 : 16'd3;
            check($sformatf("ch1_e%0d_tick", e),
                  64'(tick[1]), 64'(exp_tick));
            check($sformatf("ch1_e%0d_clk", e),
                  64'(clk_div[1]), 64'(exp_clk));
            check($sformatf("ch1_e%0d_div", e),
                  64'(div_active[W +: W]), 64'(exp_div));
        end
        wr_en = 1'b0;

        // Channel 2: N=2, then 0 and 1 while running.
        en      = '0;
        wr_en   = 1'b1;
        wr_ch   = 4'd2;
        wr_data = 16'd2;
        step();
        wr_en = 1'b0;
        step();
        check("ch2_div2", 64'(div_active[2*W +: W]), 64'd2);
        en      = 4'b0100;
        exp_clk = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            wr_en   = (e == 1) || (e == 9);
            wr_data = (e == 1) ? 16'd0 : 16'd1;
            step();
            exp_tick = (e >= 2);
            exp_clk  = exp_clk ^ exp_tick;
            exp_div  = (e < 2) ? 16'd2 :
                       (e < 10) ? 16'd0 : 16'd1;
            check($sformatf("ch2_e%0d_tick", e),
                  64'(tick[2]), 64'(exp_tick));
            check($sformatf("ch2_e%0d_clk", e),
                  64'(clk_div[2]), 64'(exp_clk));
            check($sformatf("ch2_e%0d_div", e),
                  64'(div_active[2*W +: W]), 64'(exp_div));
        end
        wr_en = 1'b0;

        // Async reset mid-count with a pending write on ch3.
        en      = 4'b1111;
        wr_en   = 1'b1;
        wr_ch   = 4'd3;
        wr_data = 16'd7;
        step();
        wr_en = 1'b0;
        repeat (3) step();
        check("pre_rst_tick2", 64'(tick[2]), 64'd1);
        #3 rst = 1'b1;
        #1;
        check("arst_tick", 64'(tick), 64'd0);
        check("arst_clk", 64'(clk_div), 64'd0);
        check("arst_div", 64'(div_active), ALL_DEF);
        repeat (2) step();
        rst = 1'b0;
        en  = '0;
        repeat (2) step();
        check("post_rst_div", 64'(div_active), ALL_DEF);
        check("post_rst_tick", 64'(tick), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
